seq_shift_add_mult: RTL and testbench

- Parametrised iterative unsigned multiplier with controller and datapath in one module.
- Successor to the repeated-addition multiplier: shift-and-add, so latency is bounded by WIDTH instead of the operand value.
- Operands arrive serially on one shared input bus: the multiplier word, then the multiplicand word on the next cycle.
- Product width is 2*WIDTH; start/busy/done handshake drives the system controller.

---
 rtl/seq_shift_add_mult.sv | 129 ++++++++++++
 tb/tb_seq_shift_add_mult.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-add unsigned multiplier: operands arrive serially on data_in, and the product is 2*WIDTH bits wide.
// Define MULT_EARLY_DONE_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_shift_add_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     data_in,
    output logic [2*WIDTH-1:0]   data_out,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_B,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q,    state_d;
    logic [WIDTH-1:0]  mplier_q,   mplier_d;
    logic [PW-1:0]     mcand_q,    mcand_d;
    logic [PW-1:0]     acc_q,      acc_d;
    logic [CW-1:0]     cnt_q,      cnt_d;
    logic [PW-1:0]     data_out_q, data_out_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic [PW-1:0]     sum;
    logic [WIDTH-1:0]  mplier_shift;
    logic              last_iter;

    // The accumulator plus this iteration's conditional add. It feeds both acc and data_out on the final edge.
    assign sum          = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mplier_shift = mplier_q >> 1;

`ifdef MULT_EARLY_DONE_EN
    assign last_iter = (cnt_q == CW'(1)) || (mplier_shift == '0);
`else
    assign last_iter = (cnt_q == CW'(1));
`endif

    always_comb begin
        // NOTE: every *_d gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        mplier_d   = mplier_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = done_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    mplier_d = data_in;
                    state_d  = S_LOAD_B;
                end
            end

            S_LOAD_B: begin
                busy_d  = 1'b1;
                mcand_d = {{WIDTH{1'b0}}, data_in};
                acc_d   = '0;
                cnt_d   = CW'(WIDTH);
                state_d = S_RUN;
            end

            S_RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q - CW'(1);
                if (last_iter) begin
                    data_out_d = sum;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_DONE;
                end
            end

            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the datapath registers are cleared on reset too, because a reset must also return data_out to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mplier_q   <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values of the others.
            state_q    <= state_d;
            mplier_q   <= mplier_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult with WIDTH=16. The reference model uses plain multiplication.
// The latency model follows MULT_EARLY_DONE_EN when that macro is defined.
module tb_seq_shift_add_mult;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     data_in = '0;
    logic [2*W-1:0]   data_out;
    logic             busy;
    logic             done;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge index, counted from the edge that samples start, at which done is expected to rise.
    function automatic int exp_lat(input logic [W-1:0] a);
`ifdef MULT_EARLY_DONE_EN
        int bl;
        bl = 0;
        for (int i = 0; i < W; i++) if (a[i]) bl = i + 1;
        return 1 + ((bl < 1) ? 1 : bl);
`else
        return W + 1;
`endif
    endfunction

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Runs one operation starting from IDLE. The task returns in the done cycle if hold is set. Otherwise it also checks the cycles that follow done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noisy, input bit hold, input string tag);
        int e;
        bit seen;
        bit busy_ok;
        logic [2*W-1:0] exp;
        exp = ref_mul(a, b);
        start = 1'b1;
        data_in = a;
        @(posedge clk); #1;
        e = 0;
        if (!hold) start = 1'b0;
        data_in = b;
        @(posedge clk); #1;
        e = 1;
        busy_ok = (busy === 1'b1);
        seen = 1'b0;
        while (!seen && e < W + 8) begin
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                data_in = '1;
            end else begin
                data_in = W'($urandom);
            end
            @(posedge clk); #1;
            e++;
            if (done === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        last_done_cyc = cyc;
        if (!hold) start = 1'b0;
        check({tag, " done_edge"}, seen ? 64'(e) : 64'hDEAD, 64'(exp_lat(a)));
        check({tag, " product"}, 64'(data_out), 64'(exp));
        check({tag, " busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        if (!hold) begin
            @(posedge clk); #1;
            check({tag, " done_pulse"}, 64'(done), 64'd0);
            check({tag, " held"}, 64'(data_out), 64'(exp));
            @(posedge clk); #1;
            check({tag, " idle_busy"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int seen2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst data_out", 64'(data_out), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(16'd3, 16'd5, 1'b0, 1'b0, "3x5");
        do_op('1, '1, 1'b0, 1'b0, "max");
        do_op(16'd0, 16'h1234, 1'b0, 1'b0, "zero");
        do_op(16'd5, 16'd7, 1'b0, 1'b0, "5x7");
        do_op(16'd12, 16'd10, 1'b1, 1'b0, "noisy12x10");

        // Back-to-back: start stays high, so the second operation begins at the first IDLE edge after DONE.
        do_op(16'd100, 16'd200, 1'b0, 1'b1, "b2b1");
        begin
            int first_done;
            first_done = last_done_cyc;
            data_in = 16'd256;
            seen2 = 0;
            for (int i = 0; i < W + 10 && seen2 == 0; i++) begin
                @(posedge clk); #1;
                if (done === 1'b1) seen2 = cyc;
            end
            start = 1'b0;
            check("b2b2 interval", 64'(seen2 - first_done), 64'(2 + exp_lat(16'd256)));
            check("b2b2 product", 64'(data_out), 64'd65536);
            repeat (3) @(posedge clk);
            #1;
        end

        // Reset in the middle of RUN. data_out holds 65536 at this point.
        start = 1'b1;
        data_in = 16'd12;
        @(posedge clk); #1;
        start = 1'b0;
        data_in = 16'd10;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst data_out", 64'(data_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_op(16'd7, 16'd9, 1'b0, 1'b0, "7x9");

        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 4 == 0) ra = ra >> $urandom_range(0, W - 1);
            do_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
